// File: rtl/lcd_timing_driver.sv
// RGB-LCD scan timing generator: HS/VS/DE, early pixel coordinates and DE-aligned panel data.
// A scan only starts or stops on a frame boundary so the panel never sees a truncated frame.
module lcd_timing_driver #(
    parameter logic [10:0] H_SYNC  = 11'd41,
    parameter logic [10:0] H_BACK  = 11'd2,
    parameter logic [10:0] H_DISP  = 11'd480,
    parameter logic [10:0] H_FRONT = 11'd2,
    parameter logic [10:0] V_SYNC  = 11'd10,
    parameter logic [10:0] V_BACK  = 11'd2,
    parameter logic [10:0] V_DISP  = 11'd272,
    parameter logic [10:0] V_FRONT = 11'd2
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_start
);

    // state | meaning
    // IDLE  | counters parked at 0, panel outputs inactive, backlight off
    // RUN   | counters scanning; leaves only at the last pixel of a frame with en low

    localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam logic [10:0] HSB     = H_SYNC + H_BACK;
    localparam logic [10:0] VSB     = V_SYNC + V_BACK;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        run;
    logic        h_end;
    logic        v_end;
    logic        v_win;
    logic        data_req;

    assign run   = (state == RUN);
    assign h_end = (h_cnt == H_TOTAL - 11'd1);
    assign v_end = (v_cnt == V_TOTAL - 11'd1);

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en)
                        state <= RUN;
                end
                RUN: begin
                    if (h_end) begin
                        h_cnt <= '0;
                        if (v_end) begin
                            v_cnt <= '0;
                            if (!en)
                                state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + 11'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 11'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase
        end
    end

    // Coordinates lead DE by one cycle so the display block's registered pixel_data lands on DE.
    assign v_win    = (v_cnt >= VSB) && (v_cnt < VSB + V_DISP);
    assign data_req = run && v_win && (h_cnt >= HSB - 11'd1) && (h_cnt < HSB + H_DISP - 11'd1);
    assign lcd_de   = run && v_win && (h_cnt >= HSB) && (h_cnt < HSB + H_DISP);

    assign lcd_hs      = !(run && (h_cnt < H_SYNC));
    assign lcd_vs      = !(run && (v_cnt < V_SYNC));
    assign pixel_xpos  = data_req ? (h_cnt - (HSB - 11'd1)) : 11'd0;
    assign pixel_ypos  = data_req ? (v_cnt - VSB) : 11'd0;
    assign lcd_rgb     = lcd_de ? pixel_data : 24'd0;
    assign frame_start = run && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    assign lcd_bl      = run;
    assign h_disp      = H_DISP;
    assign v_disp      = V_DISP;

endmodule
